fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_pc_reg.sv | 29 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and alignment helper for the instruction fetch unit.
package fetch_unit_pkg;
  localparam int XLEN        = 32;
  localparam int OPCODE_W    = 7;
  localparam int INSTR_ALIGN = 4;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_ALIGN - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr);
    return addr & ~ALIGN_MASK;
  endfunction
endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Fetch pointer: pc register, sequential +4 adder and redirect/advance mux.
module fetch_unit_pc_reg import fetch_unit_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] pc_q, pc_d, pc_seq;

  // Wraps modulo 2^XLEN naturally.
  assign pc_seq = pc_q + XLEN'(INSTR_ALIGN);

  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = target;
    else if (advance) pc_d = pc_seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-entry instruction fetch unit with stall hold and branch redirect.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_CHECK_EN.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ready,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                stall,
  input  logic                pc_src,
  input  logic [XLEN-1:0]     pc_target,
  output logic [XLEN-1:0]     instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [XLEN-1:0]     instr_pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                instr_valid,
  output logic                misalign,
  output fetch_state_e        dbg_state
);
  // Handshakes: a word transfers on imem_req && imem_ready; the held
  // instruction transfers downstream (consume) on instr_valid && !stall.
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] pc, target_aligned;
  logic            consume, fetch, redir_req, misaligned_tgt, redirect, halt_go, advance;

  assign consume   = instr_valid_q & ~stall;
  assign imem_req  = (state_q == ST_RUN) & (~instr_valid_q | ~stall);
  assign fetch     = imem_req & imem_ready;
  assign redir_req = consume & pc_src;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned_tgt = |(pc_target & ALIGN_MASK);
`else
  assign misaligned_tgt = 1'b0;
`endif

  assign redirect       = redir_req & ~misaligned_tgt;
  assign halt_go        = redir_req & misaligned_tgt;
  assign advance        = fetch & ~redir_req;
  assign target_aligned = align_down(pc_target);

  fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .redirect (redirect),
    .target   (target_aligned),
    .pc       (pc)
  );

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_go)                    state_d = ST_HALT;
        else if (instr_valid_q & stall) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (halt_go)     state_d = ST_HALT;
        else if (!stall) state_d = ST_RUN;
      end
      ST_HALT: state_d = ST_HALT;
    endcase
    // A redirect squashes any word arriving in the same cycle.
    if (redir_req) begin
      instr_valid_d = 1'b0;
    end else if (fetch) begin
      instr_d       = imem_rdata;
      instr_pc_d    = pc;
      instr_valid_d = 1'b1;
    end else if (consume) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb misalign_d = misalign_q | halt_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_W-1:0];
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = instr_pc_q + XLEN'(INSTR_ALIGN);
  assign instr_valid = instr_valid_q;
  assign dbg_state   = state_q;
endmodule
